// File: rtl/matmul_tile_loader_if.sv
// matmul_tile_loader_if: config, operand/result streams and controller command/result bundle
interface matmul_tile_loader_if #(parameter int M = 3);
  logic cfg_valid, cfg_ready, cfg_os, cfg_err;
  logic [7:0] cfg_k1, cfg_k2, cfg_k3;
  logic in_valid, in_ready;
  logic [63:0] in_data;
  logic out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic [64*M*M-1:0] A_tile_flat, W_tile_flat, C_tile_flat;
  logic [7:0] k1, k2, k3;
  logic output_stationary, start, done, busy;
  modport master (
    input cfg_valid, cfg_k1, cfg_k2, cfg_k3, cfg_os, in_valid, in_data, out_ready, done, C_tile_flat,
    output cfg_ready, cfg_err, in_ready, out_valid, out_data, out_last, A_tile_flat, W_tile_flat,
    output k1, k2, k3, output_stationary, start, busy
  );
  modport slave (
    output cfg_valid, cfg_k1, cfg_k2, cfg_k3, cfg_os, in_valid, in_data, out_ready, done, C_tile_flat,
    input cfg_ready, cfg_err, in_ready, out_valid, out_data, out_last, A_tile_flat, W_tile_flat,
    input k1, k2, k3, output_stationary, start, busy
  );
endinterface

// File: rtl/matmul_tile_loader.sv
// matmul_tile_loader: streams A/W operand tiles in, launches the systolic controller, drains C out
module matmul_tile_loader #(parameter int M = 3) (
  input logic clk,
  input logic reset,
  matmul_tile_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_W, START, WAIT, DRAIN} state_t;
  state_t state, nxt;
  logic [63:0] a_t [M*M];
  logic [63:0] w_t [M*M];
  logic [63:0] c_t [M*M];
  logic [7:0] r, c, rl, cl;
  logic [15:0] idx;
  logic last, adv, acc, bad;
  assign bus.cfg_ready = reset && state == IDLE;
  assign bus.in_ready = state == LOAD_A || state == LOAD_W;
  assign bus.start = state == START;
  assign bus.out_valid = state == DRAIN;
  assign bus.out_last = state == DRAIN && last;
  assign bus.busy = state != IDLE;
  // one row/col counter pair is shared by the A load, W load and C drain phases
  always_comb begin
    rl = state == LOAD_W ? bus.k2 : bus.k1;
    cl = state == LOAD_A ? bus.k2 : bus.k3;
    last = r == rl - 8'd1 && c == cl - 8'd1;
    idx = 16'(r * M + c);
    acc = bus.cfg_valid && bus.cfg_ready;
    bad = bus.cfg_k1 == 8'd0 || bus.cfg_k1 > 8'(M) || bus.cfg_k2 == 8'd0 || bus.cfg_k2 > 8'(M) ||
          bus.cfg_k3 == 8'd0 || bus.cfg_k3 > 8'(M);
    adv = (bus.in_valid && bus.in_ready) || (bus.out_valid && bus.out_ready);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc && !bad ? LOAD_A : IDLE;
      LOAD_A:  nxt = adv && last ? LOAD_W : LOAD_A;
      LOAD_W:  nxt = adv && last ? START : LOAD_W;
      START:   nxt = WAIT;
      WAIT:    nxt = bus.done ? DRAIN : WAIT;
      DRAIN:   nxt = adv && last ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.out_data = '0;
    bus.A_tile_flat = '0;
    bus.W_tile_flat = '0;
    for (int i = 0; i < M*M; i++) begin
      bus.A_tile_flat[64*i +: 64] = a_t[i];
      bus.W_tile_flat[64*i +: 64] = w_t[i];
      if (idx == 16'(i)) bus.out_data = c_t[i];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      r <= '0;
      c <= '0;
      bus.k1 <= '0;
      bus.k2 <= '0;
      bus.k3 <= '0;
      bus.output_stationary <= 1'b0;
      bus.cfg_err <= 1'b0;
      for (int i = 0; i < M*M; i++) begin
        a_t[i] <= '0;
        w_t[i] <= '0;
        c_t[i] <= '0;
      end
    end else begin
      state <= nxt;
      bus.cfg_err <= acc && bad;
      if (acc && !bad) begin
        bus.k1 <= bus.cfg_k1;
        bus.k2 <= bus.cfg_k2;
        bus.k3 <= bus.cfg_k3;
        bus.output_stationary <= bus.cfg_os;
        r <= '0;
        c <= '0;
        for (int i = 0; i < M*M; i++) begin
          a_t[i] <= '0;
          w_t[i] <= '0;
        end
      end
      if (adv) begin
        r <= last ? 8'd0 : c == cl - 8'd1 ? r + 8'd1 : r;
        c <= last || c == cl - 8'd1 ? 8'd0 : c + 8'd1;
      end
      for (int i = 0; i < M*M; i++) begin
        if (idx == 16'(i) && bus.in_valid && state == LOAD_A) a_t[i] <= bus.in_data;
        if (idx == 16'(i) && bus.in_valid && state == LOAD_W) w_t[i] <= bus.in_data;
        if (state == WAIT && bus.done) c_t[i] <= bus.C_tile_flat[64*i +: 64];
      end
    end
  end
endmodule

// File: tb/tb_matmul_tile_loader.sv
// tb_matmul_tile_loader: directed jobs against a real-valued matrix model plus literal pins
module tb_matmul_tile_loader;
  localparam int M = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  matmul_tile_loader_if #(.M(M)) bus();
  matmul_tile_loader #(.M(M)) dut (.clk(clk), .reset(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  real av[$];
  real wv[$];
  logic [3:0] rdy_pat = 4'b1111;
  int ph = 0;
  logic stall = 1'b0;
  logic [63:0] prev = '0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.out_ready = rdy_pat[ph];
      ph = (ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (stall) chk("stall_hold", bus.out_data, prev);
      if (exp_q.size() == 0) chk("unexpected_out", 64'(bus.out_valid), 64'd0);
      else begin
        chk("out_data", bus.out_data, exp_q[0]);
        chk("out_last", 64'(bus.out_last), 64'(exp_q.size() == 1));
        if (bus.out_ready) begin
          got_q.push_back(bus.out_data);
          void'(exp_q.pop_front());
        end
      end
    end
    stall = bus.out_valid && !bus.out_ready;
    prev = bus.out_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cfg(input int a, input int b, input int c, input logic os);
    int n = 0;
    bus.cfg_k1 = 8'(a);
    bus.cfg_k2 = 8'(b);
    bus.cfg_k3 = 8'(c);
    bus.cfg_os = os;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    while (!bus.cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_ready_wait", 64'(bus.cfg_ready), 64'd1);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
  endtask

  task automatic send(input real v);
    int n = 0;
    bus.in_data = $realtobits(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.in_data = '1;
  endtask

  task automatic run_job(input int k1, input int k2, input int k3, input logic os);
    real s;
    int n = 0;
    logic [64*M*M-1:0] sa, sw;
    for (int i = 0; i < k1; i++)
      for (int j = 0; j < k3; j++) begin
        s = 0.0;
        for (int t = 0; t < k2; t++) s += av[i*k2+t] * wv[t*k3+j];
        exp_q.push_back($realtobits(s));
      end
    got_q.delete();
    cfg(k1, k2, k3, os);
    @(negedge clk);
    chk("busy_after_cfg", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    foreach (av[i]) send(av[i]);
    foreach (wv[i]) send(wv[i]);
    @(negedge clk);
    chk("start_pulse", 64'(bus.start), 64'd1);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        chk($sformatf("a_tile%0d", r*M+c), bus.A_tile_flat[64*(r*M+c) +: 64],
            (r < k1 && c < k2) ? $realtobits(av[r*k2+c]) : 64'd0);
        chk($sformatf("w_tile%0d", r*M+c), bus.W_tile_flat[64*(r*M+c) +: 64],
            (r < k2 && c < k3) ? $realtobits(wv[r*k3+c]) : 64'd0);
      end
    chk("k1", 64'(bus.k1), 64'(k1));
    chk("k2", 64'(bus.k2), 64'(k2));
    chk("k3", 64'(bus.k3), 64'(k3));
    chk("os", 64'(bus.output_stationary), 64'(os));
    sa = bus.A_tile_flat;
    sw = bus.W_tile_flat;
    @(negedge clk);
    chk("start_single", 64'(bus.start), 64'd0);
    @(posedge clk);
    #1;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        s = 0.0;
        for (int t = 0; t < M; t++)
          s += $bitstoreal(bus.A_tile_flat[64*(r*M+t) +: 64]) * $bitstoreal(bus.W_tile_flat[64*(t*M+c) +: 64]);
        bus.C_tile_flat[64*(r*M+c) +: 64] = $realtobits(s);
      end
    bus.done = 1'b1;
    @(negedge clk);
    chk("a_stable", 64'(sa == bus.A_tile_flat), 64'd1);
    chk("w_stable", 64'(sw == bus.W_tile_flat), 64'd1);
    @(posedge clk);
    #1 bus.done = 1'b0;
    bus.C_tile_flat = '0;
    while ((exp_q.size() > 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(n < 200), 64'd1);
    chk("cfg_ready_after", 64'(bus.cfg_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_k1 = '0;
    bus.cfg_k2 = '0;
    bus.cfg_k3 = '0;
    bus.cfg_os = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.done = 1'b0;
    bus.C_tile_flat = '0;
    #3;
    chk("rst_start", 64'(bus.start), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    chk("rst_k1", 64'(bus.k1), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("cfg_ready_release", 64'(bus.cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    av = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 7.0, 8.0, 9.0};
    wv = '{1.0, 0.0, 0.0, 0.0, 1.0, 0.0, 0.0, 0.0, 1.0};
    run_job(3, 3, 3, 1'b0);
    chk("job1_count", 64'(got_q.size()), 64'd9);
    for (int i = 0; i < 9 && i < got_q.size(); i++)
      chk($sformatf("job1_out%0d", i), got_q[i], $realtobits(real'(i + 1)));
    av = '{1.0, 2.0, 3.0, 4.0};
    wv = '{2.0, 3.0, 4.0, 5.0};
    rdy_pat = 4'b1001;
    run_job(2, 2, 2, 1'b0);
    rdy_pat = 4'b1111;
    chk("job2_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("job2_out0", got_q[0], $realtobits(10.0));
      chk("job2_out1", got_q[1], $realtobits(13.0));
      chk("job2_out2", got_q[2], $realtobits(22.0));
      chk("job2_out3", got_q[3], $realtobits(29.0));
    end
    av = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0};
    wv = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0};
    run_job(2, 3, 2, 1'b1);
    chk("job3_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("job3_out0", got_q[0], $realtobits(22.0));
      chk("job3_out1", got_q[1], $realtobits(28.0));
      chk("job3_out2", got_q[2], $realtobits(49.0));
      chk("job3_out3", got_q[3], $realtobits(64.0));
    end
    cfg(0, 2, 2, 1'b0);
    @(negedge clk);
    chk("err_k1_pulse", 64'(bus.cfg_err), 64'd1);
    chk("err_k1_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("err_k1_single", 64'(bus.cfg_err), 64'd0);
    chk("err_k1_idle", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 cfg(2, 2, 4, 1'b0);
    @(negedge clk);
    chk("err_k3_pulse", 64'(bus.cfg_err), 64'd1);
    chk("err_k3_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("err_k3_single", 64'(bus.cfg_err), 64'd0);
    @(posedge clk);
    #1 bus.done = 1'b1;
    @(posedge clk);
    #1 bus.done = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", 64'(bus.busy), 64'd0);
    chk("idle_done_out", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    av = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 7.0, 8.0, 9.0};
    wv = '{1.0, 0.0, 0.0, 0.0, 1.0};
    cfg(3, 3, 3, 1'b1);
    foreach (av[i]) send(av[i]);
    foreach (wv[i]) send(wv[i]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("mid_rst_k1", 64'(bus.k1), 64'd0);
    chk("mid_rst_os", 64'(bus.output_stationary), 64'd0);
    chk("mid_rst_a_tile", 64'(bus.A_tile_flat == '0), 64'd1);
    chk("mid_rst_w_tile", 64'(bus.W_tile_flat == '0), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_start", 64'(bus.start), 64'd0);
      chk("rst_hold_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_hold_out_last", 64'(bus.out_last), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("cfg_ready_release2", 64'(bus.cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    av = '{5.0};
    wv = '{7.0};
    run_job(1, 1, 1, 1'b0);
    chk("job4_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) chk("job4_out0", got_q[0], $realtobits(35.0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
